// File: rtl/relu_bp_ctrl.sv
// rtl/relu_bp_ctrl.sv - ReLU-derivative backprop sequencer with 2-entry credit-tracked output buffer
module relu_bp_ctrl #(
  parameter int              BITWIDTH = 12,
  parameter int              BW       = BITWIDTH + 2,
  parameter int              MAX_N    = 64,
  parameter int              AW       = $clog2(MAX_N),
  parameter logic [BW-1:0]   ONE_VAL  = 14'h3FFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_sign,
  input  logic [BW-1:0] rd_grad,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_deriv,
  output logic [BW-1:0] out_grad,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_N);
  localparam logic [AW:0] ONE_CNT = (AW+1)'(1);

  state_t        state_q, state_d;

  // Pass bookkeeping: clamped length, next index to read, index of the read in flight
  logic [AW:0]   len_q;
  logic [AW:0]   rd_idx_q;
  logic [AW:0]   cap_idx_q;
  logic          inflight_q;

  // Two-entry circular output buffer; head_q points at the oldest entry
  logic [BW-1:0] fifo_deriv [2];
  logic [BW-1:0] fifo_grad  [2];
  logic          fifo_last  [2];
  logic          head_q;
  logic [1:0]    occ_q;

  logic [AW:0]   len_clamped;
  logic          pop;
  logic          push;
  logic          wr_ptr;
  logic          last_read;
  logic          cap_last;
  logic [BW-1:0] cap_deriv;

  // Datapath helpers: clamp, handshake, buffer pointers and the read-credit check
  always_comb begin
    len_clamped = (len > MAX_CNT) ? MAX_CNT : len;
    out_valid   = (occ_q != 2'd0);
    pop         = out_valid && out_ready;
    push        = inflight_q;
    wr_ptr      = head_q ^ occ_q[0];
    last_read   = (rd_idx_q == (len_q - ONE_CNT));
    cap_last    = (cap_idx_q == (len_q - ONE_CNT));
    cap_deriv   = rd_sign ? '0 : ONE_VAL;
    // occ + inflight - pop < 2, rearranged so nothing goes negative
    rd_en       = (state_q == S_RUN) &&
                  (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    rd_addr     = rd_en ? rd_idx_q[AW-1:0] : '0;
    out_deriv   = out_valid ? fifo_deriv[head_q] : '0;
    out_grad    = out_valid ? fifo_grad[head_q]  : '0;
    out_last    = out_valid ? fifo_last[head_q]  : 1'b0;
  end

  // Next-state and status decode
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len_clamped == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en && last_read) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register, pass length latch and read sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_idx_q   <= '0;
      cap_idx_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (state_q == S_IDLE && start) begin
        len_q    <= len_clamped;
        rd_idx_q <= '0;
      end else if (rd_en) begin
        rd_idx_q <= rd_idx_q + ONE_CNT;
      end
      if (rd_en) begin
        cap_idx_q <= rd_idx_q;
      end
    end
  end

  // Output buffer: capture returning read data, retire the head on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= 1'b0;
      occ_q         <= 2'd0;
      fifo_deriv[0] <= '0;
      fifo_deriv[1] <= '0;
      fifo_grad[0]  <= '0;
      fifo_grad[1]  <= '0;
      fifo_last[0]  <= 1'b0;
      fifo_last[1]  <= 1'b0;
    end else begin
      assert (!(push && !pop && occ_q == 2'd2));
      if (push) begin
        fifo_deriv[wr_ptr] <= cap_deriv;
        fifo_grad[wr_ptr]  <= rd_grad;
        fifo_last[wr_ptr]  <= cap_last;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_bp_ctrl.sv
// tb/tb_relu_bp_ctrl.sv - self-checking bench for relu_bp_ctrl
module tb_relu_bp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  len_in;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic        rd_sign;
  logic [13:0] rd_grad;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_deriv;
  logic [13:0] out_grad;
  logic        out_last;
  logic        busy;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;

  relu_bp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_sign(rd_sign), .rd_grad(rd_grad),
    .out_valid(out_valid), .out_ready(out_ready), .out_deriv(out_deriv),
    .out_grad(out_grad), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // layer buffers: one-cycle read latency
  logic        sign_mem [64];
  logic [13:0] grad_mem [64];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_sign <= sign_mem[rd_addr];
      rd_grad <= grad_mem[rd_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [13:0] d;
    logic [13:0] g;
    logic        l;
  } pair_t;

  pair_t       exp_q [$];
  logic [13:0] log_d [$];
  logic [13:0] log_g [$];
  logic        log_l [$];
  bit          active = 0;
  bit          pend_done = 0;
  bit          was_active;
  bit          hs_last;
  int          exp_len = 0;
  int          next_addr = 0;
  int          n_reads = 0;
  int          n_pops = 0;
  bit          stall_prev = 0;
  logic [13:0] prev_d, prev_g;
  logic        prev_l;
  pair_t       h;
  int          n;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      active = 0; pend_done = 0; stall_prev = 0;
      exp_len = 0; next_addr = 0; n_reads = 0; n_pops = 0;
    end else begin
      was_active = active;
      hs_last = 0;
      chk("done", done, pend_done);
      chk("busy", busy, active);
      chk("outstanding_le_2", (n_reads - n_pops) <= 2, 1);
      if (rd_en) begin
        chk("rd_allowed", next_addr < exp_len, 1);
        chk("rd_addr", rd_addr, next_addr % 64);
        next_addr++;
        n_reads++;
      end
      if (out_valid) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (stall_prev) begin
          chk("stable_deriv", out_deriv, prev_d);
          chk("stable_grad", out_grad, prev_g);
          chk("stable_last", out_last, prev_l);
        end
        if (exp_q.size() > 0) begin
          h = exp_q[0];
          chk("out_deriv", out_deriv, h.d);
          chk("out_grad", out_grad, h.g);
          chk("out_last", out_last, h.l);
          if (out_ready) begin
            void'(exp_q.pop_front());
            log_d.push_back(out_deriv);
            log_g.push_back(out_grad);
            log_l.push_back(out_last);
            n_pops++;
            hs_last = h.l;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_d = out_deriv; prev_g = out_grad; prev_l = out_last;
      if (pend_done) begin
        active = 0;
        exp_len = 0;
      end
      pend_done = hs_last;
      if (start && !was_active) begin
        n = (len_in > 64) ? 64 : int'(len_in);
        active = 1;
        exp_len = n;
        next_addr = 0; n_reads = 0; n_pops = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
          pair_t p;
          p.d = sign_mem[i] ? 14'h0000 : 14'h3FFF;
          p.g = grad_mem[i];
          p.l = (i == n - 1);
          exp_q.push_back(p);
        end
        if (n == 0) pend_done = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill_mem();
    for (int i = 0; i < 64; i++) begin
      sign_mem[i] = (i % 3 == 1);
      grad_mem[i] = 14'((i * 131 + 7) % 16384);
    end
  endtask

  // mode 0: ready=1, mode 1: ready toggles 1,0, mode 2: ready=0 through cycle 20
  task automatic run_pass(input int len, input int mode, input int restart_c,
                          input int exp_done, input int exp_pairs, input int exp_r20);
    int got;
    int r20;
    got = -1;
    r20 = 0;
    log_d.delete(); log_g.delete(); log_l.delete();
    for (int c = 0; c < 400; c++) begin
      start     = (c == 0) || (c == restart_c);
      len_in    = (c == 0) ? 7'(len) : 7'd9;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : (c > 20);
      @(negedge clk);
      if (c <= 20 && rd_en) r20++;
      if (done) begin
        got = c;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    if (exp_done >= 0) chk("done_cycle", got, exp_done);
    else chk("done_seen", got >= 0, 1);
    chk("pair_count", log_d.size(), exp_pairs);
    chk("model_drained", exp_q.size(), 0);
    if (exp_r20 >= 0) chk("reads_while_stalled", r20, exp_r20);
  endtask

  initial begin
    logic [13:0] lit_d [4];
    logic [13:0] lit_g [4];
    logic        lit_l [4];
    lit_d = '{14'h3FFF, 14'h0000, 14'h3FFF, 14'h0000};
    lit_g = '{14'h0A10, 14'h0B20, 14'h0C30, 14'h0D40};
    lit_l = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; len_in = '0; out_ready = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_deriv", out_deriv, 0);
    chk("rst_out_grad", out_grad, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;

    // len=4 basic pass
    for (int i = 0; i < 4; i++) begin
      sign_mem[i] = i[0];
      grad_mem[i] = lit_g[i];
    end
    run_pass(4, 0, -1, 7, 4, -1);
    for (int i = 0; i < 4 && i < log_d.size(); i++) begin
      chk("lit_deriv", log_d[i], lit_d[i]);
      chk("lit_grad", log_g[i], lit_g[i]);
      chk("lit_last", log_l[i], lit_l[i]);
    end

    // start re-asserted during RUN with a different len
    run_pass(4, 0, 3, 7, 4, -1);

    // len=0
    run_pass(0, 0, -1, 1, 0, -1);

    // full layer with ready toggling
    fill_mem();
    run_pass(64, 1, -1, -1, 64, -1);

    // long stall at the start
    run_pass(8, 2, -1, 29, 8, 2);

    // clamped length
    run_pass(70, 0, -1, 67, 64, -1);

    // reset during DRAIN
    start = 1'b1; len_in = 7'd2; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rd_en", rd_en, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_deriv", out_deriv, 0);
    chk("post_rst_grad", out_grad, 0);
    chk("post_rst_last", out_last, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    @(posedge clk); #1;
    sign_mem[0] = 1'b1; grad_mem[0] = 14'h1111;
    sign_mem[1] = 1'b0; grad_mem[1] = 14'h2222;
    run_pass(2, 0, -1, 5, 2, -1);
    if (log_d.size() == 2) begin
      chk("rst_pass_d0", log_d[0], 14'h0000);
      chk("rst_pass_d1", log_d[1], 14'h3FFF);
      chk("rst_pass_g1", log_g[1], 14'h2222);
      chk("rst_pass_l1", log_l[1], 1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
